// File: rtl/kmap_mux_pkg.sv
// Shared types and constants for the K-map mux engine.
package kmap_mux_pkg;

   localparam int MAX_MUX_W = 128;
   localparam int MAX_SEL_W = 7;
   localparam int MAX_CH_W  = 4;

   localparam logic [15:0] KMAP_DEFAULT_TABLE = 16'h850E;

   function automatic int ch_width(input int channels);
      return (channels > 1) ? $clog2(channels) : 1;
   endfunction

   // Sized for the largest legal configuration; instances use the low bits.
   typedef struct packed {
      logic [MAX_MUX_W-1:0] mux_in;
      logic [MAX_SEL_W-1:0] sel;
      logic [MAX_CH_W-1:0]  ch;
      logic                 err;
   } stage_payload_t;

endpackage

// File: rtl/kmap_mux_slice.sv
// Extracts the 2**SEL_BITS mux data inputs of one truth table for given low variables.
module kmap_mux_slice
   import kmap_mux_pkg::*;
#(
   parameter int N_VARS   = 4,
   parameter int SEL_BITS = 2
) (
   input  logic [2**N_VARS-1:0]        table_bits,
   input  logic [N_VARS-SEL_BITS-1:0]  low_vars,
   output logic [2**SEL_BITS-1:0]      mux_in
);

   generate
      for (genvar gi = 0; gi < 2**SEL_BITS; gi++) begin : g_k
         localparam logic [SEL_BITS-1:0] K = SEL_BITS'(gi);
         assign mux_in[gi] = table_bits[{K, low_vars}];
      end
   endgenerate

endmodule

// File: rtl/kmap_mux_engine.sv
// Two-stage programmable K-map evaluator with valid/ready flow control.
// Optional table parity checking is enabled by defining KMAP_MUX_PARITY_EN.
module kmap_mux_engine
   import kmap_mux_pkg::*;
#(
   parameter int N_VARS   = 4,
   parameter int SEL_BITS = 2,
   parameter int CHANNELS = 2,
   parameter logic [2**N_VARS-1:0] RST_TABLE = KMAP_DEFAULT_TABLE
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          cfg_we,
   input  logic [ch_width(CHANNELS)-1:0] cfg_ch,
   input  logic [2**N_VARS-1:0]          cfg_table,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [ch_width(CHANNELS)-1:0] in_ch,
   input  logic [N_VARS-1:0]             in_vars,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [2**SEL_BITS-1:0]        out_mux_in,
   output logic                          out_f,
   output logic                          out_err
);

   localparam int T    = 2**N_VARS;
   localparam int M    = 2**SEL_BITS;
   localparam int CH_W = ch_width(CHANNELS);

   logic [T-1:0]   tables_reg [CHANNELS];
   logic [T-1:0]   rd_table;
   logic [M-1:0]   mux_vec;
   logic           rd_err;
   stage_payload_t s1_reg, s1_next;
   logic           s1_valid_reg;
   logic           out_valid_reg, out_f_reg, out_err_reg;
   logic [M-1:0]   out_mux_in_reg;
   logic           accept, s2_load;
   logic [M-1:0]   s1_mux;
   logic [SEL_BITS-1:0] s1_sel;
   logic           unused_payload;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < CHANNELS; i++) tables_reg[i] <= RST_TABLE;
      end else begin
         for (int i = 0; i < CHANNELS; i++)
            if (cfg_we && cfg_ch == CH_W'(i)) tables_reg[i] <= cfg_table;
      end
   end

   // Unmatched channel index reads as an all-zero table.
   always_comb begin
      rd_table = '0;
      for (int i = 0; i < CHANNELS; i++)
         if (in_ch == CH_W'(i)) rd_table = tables_reg[i];
   end

`ifdef KMAP_MUX_PARITY_EN
   logic parity_reg [CHANNELS];
   logic rd_par;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < CHANNELS; i++) parity_reg[i] <= ^RST_TABLE;
      end else begin
         for (int i = 0; i < CHANNELS; i++)
            if (cfg_we && cfg_ch == CH_W'(i)) parity_reg[i] <= ^cfg_table;
      end
   end

   always_comb begin
      rd_par = 1'b0;
      for (int i = 0; i < CHANNELS; i++)
         if (in_ch == CH_W'(i)) rd_par = parity_reg[i];
   end

   assign rd_err = (^rd_table) ^ rd_par;
`else
   assign rd_err = 1'b0;
`endif

   kmap_mux_slice #(
      .N_VARS   (N_VARS),
      .SEL_BITS (SEL_BITS)
   ) u_slice (
      .table_bits (rd_table),
      .low_vars   (in_vars[N_VARS-SEL_BITS-1:0]),
      .mux_in     (mux_vec)
   );

   always_comb begin
      s1_next = '0;
      s1_next.mux_in[M-1:0]        = mux_vec;
      s1_next.sel[SEL_BITS-1:0]    = in_vars[N_VARS-1 -: SEL_BITS];
      s1_next.ch[CH_W-1:0]         = in_ch;
      s1_next.err                  = rd_err;
   end

   assign s2_load  = s1_valid_reg && (!out_valid_reg || out_ready);
   assign in_ready = !(s1_valid_reg && out_valid_reg && !out_ready);
   assign accept   = in_valid && in_ready;
   assign s1_mux   = s1_reg.mux_in[M-1:0];
   assign s1_sel   = s1_reg.sel[SEL_BITS-1:0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_reg         <= '0;
         s1_valid_reg   <= 1'b0;
         out_valid_reg  <= 1'b0;
         out_mux_in_reg <= '0;
         out_f_reg      <= 1'b0;
         out_err_reg    <= 1'b0;
      end else begin
         if (accept) s1_reg <= s1_next;
         s1_valid_reg <= accept || (s1_valid_reg && !s2_load);
         if (s2_load) begin
            out_mux_in_reg <= s1_mux;
            out_f_reg      <= s1_mux[s1_sel];
            out_err_reg    <= s1_reg.err;
         end
         out_valid_reg <= s2_load || (out_valid_reg && !out_ready);
      end
   end

   // Channel tag and padding bits of the payload are carried but not consumed.
   assign unused_payload = ^s1_reg;

   assign out_valid  = out_valid_reg;
   assign out_mux_in = out_mux_in_reg;
   assign out_f      = out_f_reg;
   assign out_err    = out_err_reg;

endmodule

// File: tb/tb_kmap_mux_engine.sv
// Scoreboard bench for kmap_mux_engine: truth-table reference model plus directed scenarios.
module tb_kmap_mux_engine;
   import kmap_mux_pkg::*;

   localparam int N_VARS = 4, SEL_BITS = 2, CHANNELS = 2;
   localparam int T = 16, M = 4, LOW = 2, CH_W = 1;

   logic          clk = 0;
   logic          rst_n, cfg_we, in_valid, in_ready, out_valid, out_ready, out_f, out_err;
   logic [CH_W-1:0] cfg_ch, in_ch;
   logic [T-1:0]  cfg_table;
   logic [N_VARS-1:0] in_vars;
   logic [M-1:0]  out_mux_in;

   kmap_mux_engine #(.N_VARS(N_VARS), .SEL_BITS(SEL_BITS), .CHANNELS(CHANNELS),
                     .RST_TABLE(16'h850E)) dut (
      .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_table(cfg_table),
      .in_valid(in_valid), .in_ready(in_ready), .in_ch(in_ch), .in_vars(in_vars),
      .out_valid(out_valid), .out_ready(out_ready), .out_mux_in(out_mux_in),
      .out_f(out_f), .out_err(out_err));

   always #5 clk = ~clk;

   int checks = 0, passed = 0;
   int accept_cnt = 0, out_cnt = 0;

   typedef struct { logic [M-1:0] mux; logic f; } exp_t;
   exp_t sb[$];
   logic [T-1:0] ref_tab [CHANNELS];
   logic         held = 0;
   logic [M-1:0] held_mux;
   logic         held_f;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // Reference: f is simply the table bit addressed by all variables;
   // mux input k is the bit at row k of the high-variable half-space.
   function automatic exp_t model(input int ch, input int vars);
      exp_t e;
      logic [T-1:0] tb_tab;
      int low;
      tb_tab = (ch < CHANNELS) ? ref_tab[ch] : '0;
      low = vars % (1 << LOW);
      for (int k = 0; k < M; k++) e.mux[k] = tb_tab[k * (1 << LOW) + low];
      e.f = tb_tab[vars];
      return e;
   endfunction

   initial for (int c = 0; c < CHANNELS; c++) ref_tab[c] = 16'h850E;

   // Monitor: inputs change 1 time unit after posedge, so the negedge sees the
   // exact values the next posedge will act on.
   always @(negedge clk) begin
      if (!rst_n) begin
         sb.delete();
         held = 0;
         for (int c = 0; c < CHANNELS; c++) ref_tab[c] = 16'h850E;
      end else begin
         if (in_valid && in_ready) begin
            sb.push_back(model(int'(in_ch), int'(in_vars)));
            accept_cnt++;
         end
         if (held) begin
            check("hold_valid", {31'b0, out_valid}, 32'd1);
            check("hold_mux", {28'b0, out_mux_in}, {28'b0, held_mux});
            check("hold_f", {31'b0, out_f}, {31'b0, held_f});
            held = 0;
         end
         if (out_valid) begin
            if (out_ready) begin
               if (sb.size() == 0) check("sb_underflow", 32'd1, 32'd0);
               else begin
                  exp_t e;
                  e = sb.pop_front();
                  check("sb_mux", {28'b0, out_mux_in}, {28'b0, e.mux});
                  check("sb_f", {31'b0, out_f}, {31'b0, e.f});
                  check("sb_err", {31'b0, out_err}, 32'd0);
               end
               out_cnt++;
            end else begin
               held = 1;
               held_mux = out_mux_in;
               held_f = out_f;
            end
         end
         if (cfg_we && int'(cfg_ch) < CHANNELS) ref_tab[cfg_ch] = cfg_table;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int snap_acc, snap_out, guard;
      rst_n = 1; cfg_we = 0; cfg_ch = 0; cfg_table = 0;
      in_valid = 0; in_ch = 0; in_vars = 0; out_ready = 1;
      #1 rst_n = 0;
      tick(); tick();
      check("rst_in_ready", {31'b0, in_ready}, 32'd1);
      check("rst_out_valid", {31'b0, out_valid}, 32'd0);
      check("rst_out_mux", {28'b0, out_mux_in}, 32'd0);
      check("rst_out_f", {31'b0, out_f}, 32'd0);
      check("rst_out_err", {31'b0, out_err}, 32'd0);
      rst_n = 1;
      tick();

      // Two back-to-back directed queries on the default table
      in_valid = 1; in_ch = 0; in_vars = 4'b1010;
      tick();
      in_vars = 4'b0100;
      tick();
      check("dir1_valid", {31'b0, out_valid}, 32'd1);
      check("dir1_mux", {28'b0, out_mux_in}, 32'b0101);
      check("dir1_f", {31'b0, out_f}, 32'd1);
      in_valid = 0;
      tick();
      check("dir2_mux", {28'b0, out_mux_in}, 32'b0100);
      check("dir2_f", {31'b0, out_f}, 32'd0);
      tick();

      // Exhaustive sweep on both channels of the default table
      for (int c = 0; c < CHANNELS; c++)
         for (int v = 0; v < 16; v++) begin
            in_valid = 1; in_ch = CH_W'(c); in_vars = 4'(v);
            tick();
         end
      in_valid = 0;
      tick(); tick();

      // Write/query collision on channel 1
      cfg_we = 1; cfg_ch = 1; cfg_table = 16'hFFFF;
      in_valid = 1; in_ch = 1; in_vars = 4'b0101;
      tick();
      cfg_we = 0;
      tick();
      check("coll_old_f", {31'b0, out_f}, 32'd0);
      in_valid = 0;
      tick();
      check("coll_new_f", {31'b0, out_f}, 32'd1);
      check("coll_new_mux", {28'b0, out_mux_in}, 32'b1111);
      tick();

      // Backpressure: five offered, two held
      out_ready = 0;
      snap_acc = accept_cnt;
      snap_out = out_cnt;
      for (int q = 0; q < 5; q++) begin
         in_valid = 1; in_ch = 0; in_vars = 4'(q * 3);
         tick();
      end
      in_valid = 0;
      tick();
      check("bp_accepted", accept_cnt - snap_acc, 32'd2);
      check("bp_in_ready", {31'b0, in_ready}, 32'd0);
      check("bp_out_valid", {31'b0, out_valid}, 32'd1);
      out_ready = 1;
      tick(); tick(); tick();
      check("bp_drained", out_cnt - snap_out, 32'd2);
      check("bp_sb_empty", sb.size(), 32'd0);

      // Randomized traffic with table rewrites and random backpressure
      for (int i = 0; i < 400; i++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         in_ch     = CH_W'($urandom_range(0, CHANNELS - 1));
         in_vars   = 4'($urandom);
         cfg_we    = ($urandom_range(0, 7) == 0);
         cfg_ch    = CH_W'($urandom_range(0, CHANNELS - 1));
         cfg_table = 16'($urandom);
         out_ready = ($urandom_range(0, 9) < 7);
         tick();
      end
      in_valid = 0; cfg_we = 0; out_ready = 1;
      guard = 0;
      while (sb.size() != 0 && guard < 20) begin
         tick();
         guard++;
      end
      check("rand_drain", sb.size(), 32'd0);

      // Reset mid-stream after clobbering channel 0
      cfg_we = 1; cfg_ch = 0; cfg_table = 16'h0000;
      tick();
      cfg_we = 0;
      out_ready = 0;
      in_valid = 1; in_ch = 0; in_vars = 4'b0011;
      tick();
      in_vars = 4'b1100;
      tick();
      in_valid = 0;
      rst_n = 0;
      #1;
      check("mid_rst_out_valid", {31'b0, out_valid}, 32'd0);
      @(posedge clk);
      #2 rst_n = 1;
      out_ready = 1;
      tick();
      check("post_rst_in_ready", {31'b0, in_ready}, 32'd1);
      check("post_rst_out_valid", {31'b0, out_valid}, 32'd0);
      in_valid = 1; in_ch = 0; in_vars = 4'b1010;
      tick();
      in_valid = 0;
      tick();
      check("post_rst_mux", {28'b0, out_mux_in}, 32'b0101);
      check("post_rst_f", {31'b0, out_f}, 32'd1);
      tick(); tick();
      check("final_sb_empty", sb.size(), 32'd0);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, expected completion");
      $fatal(1);
   end

endmodule
